// File: rtl/input_acc_loader_pkg.sv
// Shared types and sizing helpers for the input-accumulator loader.
// Holds the loader FSM states, default geometry and count-width helpers.
package input_acc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      DRAIN,
      DONE
   } acc_state_t;

   localparam int DEF_LANES  = 2;
   localparam int DEF_DEPTH  = 4;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;

   // Width able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width of the drain counter, which reaches depth+lanes-2.
   function automatic int drain_w(input int depth, input int lanes);
      return $clog2(depth + lanes) + 1;
   endfunction

endpackage

// File: rtl/input_acc_loader_skew.sv
// Diagonal dequeue mask: lane i is requested while i <= d < i+eff_n.
// Ports: d (drain counter), eff_n (vectors loaded), mask (per-lane request).
module input_acc_skew
   import input_acc_pkg::*;
#(
   parameter int LANES = DEF_LANES,
   parameter int DW    = 4,
   parameter int NW    = 3
) (
   input  logic [DW-1:0]    d,
   input  logic [NW-1:0]    eff_n,
   output logic [LANES-1:0] mask
);

   localparam int SW = ((DW > NW) ? DW : NW) + 2;

   genvar i;
   generate
      for (i = 0; i < LANES; i++) begin : g_lane
         localparam logic [SW-1:0] LO = SW'(i);
         // d-LO wraps to a huge value when d < LO, so one
         // unsigned compare covers both window edges.
         assign mask[i] = (SW'(d) - LO) < SW'(eff_n);
      end
   endgenerate

endmodule

// File: rtl/input_acc_loader.sv
// Loads a block of vectors from the unified buffer into the per-row
// input-acc FIFOs, then issues skewed dequeues to form a wavefront.
// Ports: clk, rst (async active-low), start/base_addr/num_vec command,
// ub_rd_* buffer read, acc_* FIFO write/dequeue, busy, done.
// Optional: INPUT_ACC_LOADER_PERF_EN adds perf_cycles[15:0].
module input_acc_loader
   import input_acc_pkg::*;
#(
   parameter int  LANES  = DEF_LANES,
   parameter int  DEPTH  = DEF_DEPTH,
   parameter int  ADDR_W = DEF_ADDR_W,
   parameter int  DATA_W = DEF_DATA_W,
   localparam int NW     = cnt_w(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [NW-1:0]           num_vec,
   output logic                    ub_rd_en,
   output logic [ADDR_W-1:0]       ub_rd_addr,
   input  logic [LANES*DATA_W-1:0] ub_rd_data,
   output logic [LANES-1:0]        acc_valid_data_out,
   output logic [LANES*DATA_W-1:0] acc_data_out,
   output logic [LANES-1:0]        acc_valid_in_out,
   output logic                    busy,
   output logic                    done
`ifdef INPUT_ACC_LOADER_PERF_EN
   ,
   output logic [15:0]             perf_cycles
`endif
);

   localparam int DW = drain_w(DEPTH, LANES);

   acc_state_t        state;
   acc_state_t        state_nx;
   logic [ADDR_W-1:0] base_q;
   logic [NW-1:0]     eff_n;
   logic [NW-1:0]     req_n;
   logic [DW-1:0]     cnt;
   logic              rd_pend;
   logic              load_last;
   logic              drain_last;
   logic              drain_en;
   logic [LANES-1:0]  skew_mask;

   assign req_n = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;

   assign load_last  = (cnt + DW'(1)) == DW'(eff_n);
   assign drain_last = (cnt + DW'(1)) ==
                       (DW'(eff_n) + DW'(LANES - 1));

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Command capture, phase counter and write-pending flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q  <= '0;
         eff_n   <= '0;
         cnt     <= '0;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= ub_rd_en;
         if (state == IDLE && start) begin
            base_q <= base_addr;
            eff_n  <= req_n;
         end
         // Counter restarts on every state change so it doubles
         // as the load index k and the drain index d.
         if (state != state_nx) begin
            cnt <= '0;
         end else if (state == LOAD || state == DRAIN) begin
            cnt <= cnt + DW'(1);
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = (req_n == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (load_last) begin
               state_nx = FLUSH;
            end
         end
         FLUSH: begin
            state_nx = DRAIN;
         end
         DRAIN: begin
            if (drain_last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      ub_rd_en   = 1'b0;
      ub_rd_addr = '0;
      busy       = 1'b0;
      done       = 1'b0;
      drain_en   = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
         end
         LOAD: begin
            busy       = 1'b1;
            ub_rd_en   = 1'b1;
            ub_rd_addr = base_q + ADDR_W'(cnt);
         end
         FLUSH: begin
            busy = 1'b1;
         end
         DRAIN: begin
            busy     = 1'b1;
            drain_en = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   input_acc_skew #(
      .LANES (LANES),
      .DW    (DW),
      .NW    (NW)
   ) u_skew (
      .d     (cnt),
      .eff_n (eff_n),
      .mask  (skew_mask)
   );

   assign acc_valid_in_out   = drain_en ? skew_mask : '0;
   assign acc_valid_data_out = {LANES{rd_pend}};
   // Buffer data lands one cycle after the strobe; held at zero
   // otherwise so the write bus is quiet outside write cycles.
   assign acc_data_out       = rd_pend ? ub_rd_data : '0;

`ifdef INPUT_ACC_LOADER_PERF_EN
   logic [15:0] perf_run;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_run    <= '0;
         perf_cycles <= '0;
      end else begin
         if (state == IDLE) begin
            perf_run <= '0;
         end else if (perf_run != 16'hFFFF) begin
            perf_run <= perf_run + 16'd1;
         end
         // perf_run excludes the DONE cycle itself, hence the +1.
         if (state == DONE) begin
            perf_cycles <= (perf_run == 16'hFFFF) ?
                           perf_run : perf_run + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_input_acc_loader.sv
// Self-checking bench for input_acc_loader: timeline model of each
// accepted command, per-cycle compare, plus literal scenario checks.
module tb_input_acc_loader;

   localparam int LANES = 2;
   localparam int DEPTH = 4;
   localparam int MAXC  = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [2:0]  num_vec = '0;
   logic        ub_rd_en;
   logic [15:0] ub_rd_addr;
   logic [31:0] ub_rd_data = '0;
   logic [1:0]  acc_valid_data_out;
   logic [31:0] acc_data_out;
   logic [1:0]  acc_valid_in_out;
   logic        busy;
   logic        done;

   input_acc_loader #(
      .LANES  (LANES),
      .DEPTH  (DEPTH),
      .ADDR_W (16),
      .DATA_W (16)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .start              (start),
      .base_addr          (base_addr),
      .num_vec            (num_vec),
      .ub_rd_en           (ub_rd_en),
      .ub_rd_addr         (ub_rd_addr),
      .ub_rd_data         (ub_rd_data),
      .acc_valid_data_out (acc_valid_data_out),
      .acc_data_out       (acc_data_out),
      .acc_valid_in_out   (acc_valid_in_out),
      .busy               (busy),
      .done               (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int free_at = 0;
   int n_chk = 0;
   int n_err = 0;

   bit        e_rd   [MAXC];
   bit [15:0] e_addr [MAXC];
   bit        e_wr   [MAXC];
   bit [31:0] e_data [MAXC];
   bit [1:0]  e_deq  [MAXC];
   bit        e_busy [MAXC];
   bit        e_done [MAXC];

   bit        o_rd   [MAXC];
   bit [15:0] o_addr [MAXC];
   bit [1:0]  o_wr   [MAXC];
   bit [31:0] o_data [MAXC];
   bit [1:0]  o_deq  [MAXC];
   bit        o_busy [MAXC];
   bit        o_done [MAXC];

   always @(posedge clk) cyc++;

   // Buffer contents: lane0 = a-0x0F, lane1 = {lo(a-0x0F), lo(a-0x0E)}
   function automatic logic [31:0] ub_word(input logic [15:0] a);
      logic [15:0] k;
      logic [15:0] k1;
      k  = a - 16'h000F;
      k1 = k + 16'd1;
      return {k[7:0], k1[7:0], k};
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  name, cyc, act, exp);
      end
   endtask

   // Timeline of one accepted command issued in cycle t.
   function automatic void sched(input int t,
                                 input logic [15:0] b,
                                 input int nv);
      int n;
      int dn;
      n = (nv > DEPTH) ? DEPTH : nv;
      if (n == 0) begin
         dn = t + 1;
      end else begin
         dn = t + 2 * n + LANES + 1;
         for (int k = 0; k < n; k++) begin
            logic [15:0] a;
            a = b + 16'(k);
            e_rd[t + 1 + k]   = 1'b1;
            e_addr[t + 1 + k] = a;
            e_wr[t + 2 + k]   = 1'b1;
            e_data[t + 2 + k] = ub_word(a);
         end
         for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < n; j++) begin
               e_deq[t + n + 2 + i + j][i] = 1'b1;
            end
         end
      end
      for (int c = t + 1; c <= dn; c++) begin
         e_busy[c] = 1'b1;
      end
      e_done[dn] = 1'b1;
      free_at = dn + 1;
   endfunction

   // Unified-buffer responder: data valid one cycle after the strobe.
   bit        r_en;
   bit [15:0] r_addr;

   always @(negedge clk) begin
      r_en   = ub_rd_en;
      r_addr = ub_rd_addr;
   end

   always @(posedge clk) begin
      #1;
      ub_rd_data = r_en ? ub_word(r_addr) : $urandom;
   end

   // Per-cycle compare against the model, also recording outputs.
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         o_rd[cyc]   = ub_rd_en;
         o_addr[cyc] = ub_rd_addr;
         o_wr[cyc]   = acc_valid_data_out;
         o_data[cyc] = acc_data_out;
         o_deq[cyc]  = acc_valid_in_out;
         o_busy[cyc] = busy;
         o_done[cyc] = done;
         chk("rd_en", 32'(ub_rd_en), 32'(e_rd[cyc]));
         if (e_rd[cyc]) begin
            chk("rd_addr", 32'(ub_rd_addr), 32'(e_addr[cyc]));
         end
         chk("wr_vld", 32'(acc_valid_data_out),
             32'({2{e_wr[cyc]}}));
         if (e_wr[cyc]) begin
            chk("wr_data", acc_data_out, e_data[cyc]);
         end
         chk("deq", 32'(acc_valid_in_out), 32'(e_deq[cyc]));
         chk("busy", 32'(busy), 32'(e_busy[cyc]));
         chk("done", 32'(done), 32'(e_done[cyc]));
      end
   end

   task automatic step(input bit st,
                       input logic [15:0] b,
                       input logic [2:0] nv);
      @(posedge clk);
      #1;
      start     = st;
      base_addr = b;
      num_vec   = nv;
      if (st && rst && cyc >= free_at) begin
         sched(cyc, b, int'(nv));
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_rd_en"}, 32'(ub_rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(ub_rd_addr), 32'd0);
      chk({tag, "_wr_vld"}, 32'(acc_valid_data_out), 32'd0);
      chk({tag, "_wr_data"}, acc_data_out, 32'd0);
      chk({tag, "_deq"}, 32'(acc_valid_in_out), 32'd0);
   endtask

   // Assert reset between edges, hold, release; model restarts idle.
   task automatic mid_reset(input int hold);
      #2;
      rst = 1'b0;
      for (int c = cyc; c < MAXC; c++) begin
         e_rd[c]   = 1'b0;
         e_wr[c]   = 1'b0;
         e_deq[c]  = '0;
         e_busy[c] = 1'b0;
         e_done[c] = 1'b0;
      end
      #1;
      chk_quiet("mid_rst");
      repeat (hold) step(1'b0, '0, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      start = 1'b0;
      free_at = cyc;
   endtask

   function automatic int win_cnt(input int sel,
                                  input int a,
                                  input int b);
      int s;
      s = 0;
      for (int c = a; c <= b; c++) begin
         case (sel)
            0: s += int'(o_rd[c]);
            1: s += int'(o_wr[c] == 2'b11);
            2: s += int'(o_deq[c][0]);
            3: s += int'(o_deq[c][1]);
            default: s += int'(o_done[c]);
         endcase
      end
      return s;
   endfunction

   int t1, t2, t3, t4, t5, t6, t7;
   int r;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_quiet("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      free_at = cyc;
      step(1'b0, '0, '0);

      // Reference block of three vectors
      step(1'b1, 16'h0010, 3'd3);
      t1 = cyc;
      repeat (12) step(1'b0, '0, '0);
      chk("t1_rd_cnt", 32'(win_cnt(0, t1, t1 + 11)), 32'd3);
      chk("t1_addr0", 32'(o_addr[t1 + 1]), 32'h0010);
      chk("t1_addr2", 32'(o_addr[t1 + 3]), 32'h0012);
      chk("t1_wr_first", 32'(o_wr[t1 + 2]), 32'd3);
      chk("t1_l0_d1", 32'(o_data[t1 + 2][15:0]), 32'h0001);
      chk("t1_l0_d3", 32'(o_data[t1 + 4][15:0]), 32'h0003);
      chk("t1_l1_d3", 32'(o_data[t1 + 4][31:16]), 32'h0304);
      chk("t1_deq5", 32'(o_deq[t1 + 5]), 32'd1);
      chk("t1_deq6", 32'(o_deq[t1 + 6]), 32'd3);
      chk("t1_deq8", 32'(o_deq[t1 + 8]), 32'd2);
      chk("t1_deq9", 32'(o_deq[t1 + 9]), 32'd0);
      chk("t1_done8", 32'(o_done[t1 + 8]), 32'd0);
      chk("t1_done9", 32'(o_done[t1 + 9]), 32'd1);
      chk("t1_busy9", 32'(o_busy[t1 + 9]), 32'd1);
      chk("t1_busy10", 32'(o_busy[t1 + 10]), 32'd0);

      // Empty command
      step(1'b1, 16'h1234, 3'd0);
      t2 = cyc;
      repeat (4) step(1'b0, '0, '0);
      chk("t2_done1", 32'(o_done[t2 + 1]), 32'd1);
      chk("t2_rd", 32'(win_cnt(0, t2, t2 + 4)), 32'd0);
      chk("t2_wr", 32'(win_cnt(1, t2, t2 + 4)), 32'd0);
      chk("t2_deq", 32'(win_cnt(2, t2, t2 + 4) +
                        win_cnt(3, t2, t2 + 4)), 32'd0);

      // Clamp 7 -> 4
      step(1'b1, 16'h0100, 3'd7);
      t3 = cyc;
      repeat (16) step(1'b0, '0, '0);
      chk("t3_rd", 32'(win_cnt(0, t3, t3 + 15)), 32'd4);
      chk("t3_wr", 32'(win_cnt(1, t3, t3 + 15)), 32'd4);
      chk("t3_l1_deq", 32'(win_cnt(3, t3, t3 + 15)), 32'd4);
      chk("t3_l1_d0", 32'(o_deq[t3 + 6][1]), 32'd0);
      chk("t3_l1_d1", 32'(o_deq[t3 + 7][1]), 32'd1);
      chk("t3_done", 32'(o_done[t3 + 11]), 32'd1);

      // Address wrap
      step(1'b1, 16'hFFFF, 3'd2);
      t4 = cyc;
      repeat (10) step(1'b0, '0, '0);
      chk("t4_addr0", 32'(o_addr[t4 + 1]), 32'hFFFF);
      chk("t4_addr1", 32'(o_addr[t4 + 2]), 32'h0000);
      chk("t4_neg_l0", 32'(o_data[t4 + 2][15:0]), 32'hFFF0);
      chk("t4_wrap_l0", 32'(o_data[t4 + 3][15:0]), 32'hFFF1);

      // Start during LOAD and during DONE is ignored
      step(1'b1, 16'h0040, 3'd2);
      t5 = cyc;
      step(1'b1, 16'h0050, 3'd3);
      step(1'b1, 16'h0050, 3'd3);
      repeat (4) step(1'b0, '0, '0);
      step(1'b1, 16'h0060, 3'd1);
      repeat (7) step(1'b0, '0, '0);
      chk("t5_addr", 32'(o_addr[t5 + 1]), 32'h0040);
      chk("t5_rd", 32'(win_cnt(0, t5, t5 + 13)), 32'd2);
      chk("t5_done", 32'(win_cnt(4, t5, t5 + 13)), 32'd1);

      // Reset in the middle of DRAIN, then a fresh one-vector op
      step(1'b1, 16'h0080, 3'd4);
      t6 = cyc;
      repeat (6) step(1'b0, '0, '0);
      mid_reset(2);
      step(1'b1, 16'h0020, 3'd1);
      t7 = cyc;
      repeat (8) step(1'b0, '0, '0);
      chk("t6_busy_rst", 32'(o_busy[t6 + 7]), 32'd0);
      chk("t7_rd", 32'(o_rd[t7 + 1]), 32'd1);
      chk("t7_addr", 32'(o_addr[t7 + 1]), 32'h0020);
      chk("t7_deq0", 32'(o_deq[t7 + 3]), 32'd1);
      chk("t7_deq1", 32'(o_deq[t7 + 4]), 32'd2);
      chk("t7_done", 32'(o_done[t7 + 5]), 32'd1);

      // Random commands with occasional asynchronous resets
      for (int it = 0; it < 1500 && cyc < MAXC - 60; it++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            mid_reset($urandom_range(1, 3));
         end else if (r < 30) begin
            step(1'b1, 16'($urandom), 3'($urandom_range(0, 7)));
         end else begin
            step(1'b0, 16'($urandom), 3'($urandom));
         end
      end
      repeat (20) step(1'b0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
